// File: rtl/fp_mul_pkg.sv
// Shared types for the fp_mul scheduler.
//   rmode_e    : IEEE rounding modes understood by fp_mul
//   RM_DEFAULT : mode substituted when a request carries an illegal code
//   mul_req_t  : operands plus rounding mode held in stage 1
//   mul_resp_t : product plus flags held in stage 2
package fp_mul_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rmode_e;

    localparam rmode_e RM_DEFAULT = RNE;

    typedef struct packed {
        logic [31:0] X;
        logic [31:0] Y;
        rmode_e      rmode;
    } mul_req_t;

    typedef struct packed {
        logic [31:0] Z;
        logic        ovrf;
        logic        udrf;
        logic        rm_err;
    } mul_resp_t;

    // Codes 101..111 have no defined rounding behaviour.
    function automatic logic rm_illegal(input logic [2:0] rm);
        return rm > 3'b100;
    endfunction

endpackage

// File: rtl/fp_mul_sched_if.sv
// Bundle of all non-clock signals around the fp_mul scheduler.
//   req_*      : per-requester valid/ready request ports (packed per lane)
//   mul_*      : operands to / result from the shared fp_mul datapath
//   resp_*     : single tagged response port with backpressure
//   op_count   : completed-response counter, busy : any stage occupied
// master = requesters, response consumer and the fp_mul instance.
// slave  = the scheduler.
interface fp_mul_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 16
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0][31:0] req_X;
    logic [N_REQ-1:0][31:0] req_Y;
    logic [N_REQ-1:0][2:0]  req_rmode;

    logic [31:0]            mul_fp_X;
    logic [31:0]            mul_fp_Y;
    logic [2:0]             mul_r_mode;
    logic [31:0]            mul_fp_Z;
    logic                   mul_ovrf;
    logic                   mul_udrf;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [31:0]            resp_Z;
    logic                   resp_ovrf;
    logic                   resp_udrf;
    logic                   resp_rm_err;

    logic [CNT_W-1:0]       op_count;
    logic                   busy;

    modport master (
        output req_valid, req_X, req_Y, req_rmode, resp_ready,
               mul_fp_Z, mul_ovrf, mul_udrf,
        input  req_ready, mul_fp_X, mul_fp_Y, mul_r_mode,
               resp_valid, resp_id, resp_Z, resp_ovrf, resp_udrf, resp_rm_err,
               op_count, busy
    );

    modport slave (
        input  req_valid, req_X, req_Y, req_rmode, resp_ready,
               mul_fp_Z, mul_ovrf, mul_udrf,
        output req_ready, mul_fp_X, mul_fp_Y, mul_r_mode,
               resp_valid, resp_id, resp_Z, resp_ovrf, resp_udrf, resp_rm_err,
               op_count, busy
    );

endinterface

// File: rtl/fp_mul_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or above ptr,
// wrapping modulo N_REQ.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant (zero when nothing requests)
//   gnt_idx : index of the granted requester
//   gnt_any : some requester was granted
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        int k;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        k       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr) + i) % N_REQ;
            if (!gnt_any && req[k]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(k);
                gnt[k]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_sched.sv
// Shares one combinational fp_mul among N_REQ requesters.
// S1 registers the granted operands and drives fp_mul directly; S2 captures
// the product and flags and presents them on the tagged response port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request, fp_mul and response signals (slave side)
module fp_mul_sched
    import fp_mul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    fp_mul_sched_if.slave bus
);

    logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic             s1_err_q, s1_err_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    mul_req_t         s1_q, s1_d;
    mul_resp_t        s2_q, s2_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic             s2_adv, s1_free, take;
    logic [2:0]       rm_in;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        // S1 may refill in the same cycle S2 drains, so no bubble appears.
        s2_adv  = s1_v_q && (!s2_v_q || bus.resp_ready);
        s1_free = !s1_v_q || s2_adv;
        // rst gating keeps req_ready low while reset is held.
        take    = s1_free && gnt_any && !rst;
        bus.req_ready = take ? gnt : '0;

        rm_in    = bus.req_rmode[gnt_idx];
        s1_v_d   = s1_v_q;
        s1_d     = s1_q;
        s1_id_d  = s1_id_q;
        s1_err_d = s1_err_q;
        rr_ptr_d = rr_ptr_q;
        if (take) begin
            s1_v_d   = 1'b1;
            s1_id_d  = gnt_idx;
            s1_err_d = rm_illegal(rm_in);
            s1_d.X   = bus.req_X[gnt_idx];
            s1_d.Y   = bus.req_Y[gnt_idx];
            // Illegal modes still execute, rounded to nearest-even.
            s1_d.rmode = rm_illegal(rm_in) ? RM_DEFAULT : rmode_e'(rm_in);
            rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (s2_adv) begin
            // Operands stay on the mul_* pins; only the valid drops.
            s1_v_d = 1'b0;
        end

        s2_v_d  = s2_v_q;
        s2_d    = s2_q;
        s2_id_d = s2_id_q;
        if (s2_adv) begin
            s2_v_d  = 1'b1;
            s2_id_d = s1_id_q;
            s2_d    = '{Z: bus.mul_fp_Z, ovrf: bus.mul_ovrf,
                        udrf: bus.mul_udrf, rm_err: s1_err_q};
        end else if (bus.resp_ready) begin
            s2_v_d = 1'b0;
        end

        cnt_d = cnt_q + CNT_W'(s2_v_q && bus.resp_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            s1_id_q  <= '0;
            s2_id_q  <= '0;
            s1_err_q <= 1'b0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s2_v_q   <= s2_v_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s1_id_q  <= s1_id_d;
            s2_id_q  <= s2_id_d;
            s1_err_q <= s1_err_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.mul_fp_X    = s1_q.X;
    assign bus.mul_fp_Y    = s1_q.Y;
    assign bus.mul_r_mode  = s1_q.rmode;
    assign bus.resp_valid  = s2_v_q;
    assign bus.resp_id     = s2_id_q;
    assign bus.resp_Z      = s2_q.Z;
    assign bus.resp_ovrf   = s2_q.ovrf;
    assign bus.resp_udrf   = s2_q.udrf;
    assign bus.resp_rm_err = s2_q.rm_err;
    assign bus.op_count    = cnt_q;
    assign bus.busy        = s1_v_q || s2_v_q;

endmodule

// File: doc/fp_mul_sched.md
Name: fp_mul_sched

Overview:
- Round-robin scheduler that shares one combinational fp_mul datapath among N_REQ requesters.
- Each requester has a valid/ready request port. The block registers the winning operands, drives the multiplier, and registers its result with flags. It returns the result on a single tagged response port with backpressure.
- Sits between the ALU issue logic and the fp_mul instance inside the FPU.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, $clog2(N_REQ), width of requester tag
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  request valid per requester
req_ready  out  N_REQ  request accepted this cycle (one-hot or zero)
req_X  in  32*N_REQ  operand X per requester, IEEE-754 single
req_Y  in  32*N_REQ  operand Y per requester
req_rmode  in  3*N_REQ  rounding mode per requester (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM)
mul_fp_X  out  32  operand X to fp_mul
mul_fp_Y  out  32  operand Y to fp_mul
mul_r_mode  out  3  rounding mode to fp_mul
mul_fp_Z  in  32  fp_mul result (combinational from mul_* outputs)
mul_ovrf  in  1  fp_mul overflow flag
mul_udrf  in  1  fp_mul underflow flag
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_id  out  ID_W  requester index of response
resp_Z  out  32  product
resp_ovrf  out  1  overflow flag
resp_udrf  out  1  underflow flag
resp_rm_err  out  1  request carried an illegal rounding mode (101..111)
op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W
busy  out  1  any stage occupied

Behaviour:
- Reset (async, rst=1):
  - Stage-1 valid s1_v=0 and stage-2 valid s2_v=0; rr_ptr=0; op_count=0.
  - resp_valid=0, resp_id=0, resp_Z=0, resp_ovrf=0, resp_udrf=0, resp_rm_err=0.
  - mul_fp_X=0, mul_fp_Y=0, mul_r_mode=0; req_ready=0; busy=0.
- Pipeline:
  - S1 holds the accepted operands and drives mul_fp_X, mul_fp_Y and mul_r_mode directly from registers.
  - S2 captures mul_fp_Z, mul_ovrf and mul_udrf, plus the tag and rm_err carried from S1.
  - Latency from req handshake to resp_valid is exactly 2 cycles when there is no backpressure.
  - Throughput is 1 operation per cycle.
- Stall rules:
  - s2_adv = s1_v && (!s2_v || resp_ready).
  - s1_free = !s1_v || s2_adv.
  - The S2 response fields are held stable while resp_valid && !resp_ready.
- Arbitration:
  - Only when s1_free. Grant the first asserted req_valid searching from rr_ptr upward, modulo N_REQ.
  - req_ready[g]=1 combinationally for the granted g only; req_ready=0 when !s1_free.
  - On a grant, rr_ptr <= (g+1) mod N_REQ; otherwise rr_ptr holds.
  - req_ready never depends on req_X, req_Y or req_rmode.
- Illegal rounding mode (req_rmode >= 101): the operation is still executed with mul_r_mode=000 and rm_err=1 is carried with it.
- S1 on an idle cycle: when no grant and s2_adv, s1_v <= 0. mul_* operands hold their last value; they are not zeroed.
- S2 on an idle cycle: when resp_ready && !s2_adv, s2_v <= 0.
- Simultaneous S2 drain and S1 refill is required, so there are no bubbles.
- op_count increments on each resp_valid && resp_ready and wraps from 2^CNT_W-1 to 0.
- busy = s1_v || s2_v.
- Reset asserted mid-operation discards all in-flight operations; no response is emitted for them.

Decomposition:
- Package fp_mul_pkg holds:
  - the rounding-mode enum rmode_e (RNE, RTZ, RDN, RUP, RMM);
  - constant RM_DEFAULT = RNE;
  - struct mul_req_t {X, Y, rmode};
  - struct mul_resp_t {Z, ovrf, udrf, rm_err}.
- One sub-module, rr_arbiter (N_REQ, request vector, pointer → one-hot grant plus index). Pipeline registers and the counter stay in fp_mul_sched.

Test Plan:
- Single request: req 0 sends X=0x40400000, Y=0x40400000, rmode=001 with resp_ready=1.
  - Expect mul_* equal to the operands in cycle 1 and resp_valid in cycle 2.
  - Expect resp_id=0, resp_Z=0x41100000, ovrf=udrf=0, op_count=1.
- Fairness: all 4 requesters hold valid continuously for 8 grants.
  - Grant order must be 0,1,2,3,0,1,2,3, with one req_ready per cycle.
  - resp_id follows the same order 2 cycles later.
- Backpressure: hold resp_ready=0 for 5 cycles with 3 requests pending.
  - S2 holds, S1 fills, and req_ready=0 after S1 is occupied.
  - On release, responses arrive back-to-back with no loss or duplication.
- Illegal rounding mode: req 2 sends X=0x3F800000, Y=0x40000000, rmode=110.
  - Expect mul_r_mode=000, resp_Z=0x40000000, resp_rm_err=1.
- Zero and flag pass-through: X=0x00000000, Y=0x80000000 gives resp_Z=0x80000000.
  - A model driving mul_udrf=1 must show resp_udrf=1 on the tagged response.
- Reset and wrap:
  - Assert rst with both stages full: resp_valid=0 and busy=0 immediately (async), and no stale response after release.
  - Preload op_count to 0xFFFF via 65535 completions; one more completion gives 0x0000.
